zhegalkin_coef: RTL and testbench

- Upstream stage of the 4-input Zhegalkin polynomial evaluator.
- Accepts a truth table of an N-input Boolean function and computes its Zhegalkin (ANF) coefficient vector with an iterative Möbius transform, one butterfly pass per clock.
- The resulting vector is what the evaluator's XOR-of-monomials network is built from. Degree and monomial count are reported alongside.
- Valid/ready handshakes on both sides.

---
 rtl/zhegalkin_pkg.sv | 25 ++
 rtl/mobius_pass.sv | 36 +++
 rtl/zhegalkin_coef.sv | 102 ++++++++++
 tb/tb_zhegalkin_coef.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/zhegalkin_pkg.sv
// Shared definitions for the Zhegalkin (ANF) coefficient block and the
// downstream polynomial evaluator.
//   N_DEFAULT : default number of Boolean function inputs
//   state_e   : sequencer states of the coefficient block
//   popcount  : number of set bits in a 32-bit word (used for degree/nterms)
package zhegalkin_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFORM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      c = c + 6'((v >> i) & 32'd1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mobius_pass.sv
// Single butterfly pass of the binary Moebius transform (purely combinational).
//   a_i     : W-bit input vector
//   stage_i : pass index k (0 .. N-1)
//   a_o     : a_o[i] = a_i[i] ^ a_i[i ^ (1<<k)] where bit k of i is set,
//             otherwise a_o[i] = a_i[i]
module mobius_pass #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic [(1 << N)-1:0] a_i,
  input  logic [SW-1:0]       stage_i,
  output logic [(1 << N)-1:0] a_o
);

  localparam int unsigned W = 1 << N;

  // Positions whose index has bit k set: the ones that absorb a partner.
  function automatic logic [W-1:0] hi_mask(input int unsigned k);
    logic [W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (((i >> k) & 32'd1) != 32'd0) m = m | (W'(1) << i);
    end
    return m;
  endfunction

  // Shifting left by 2^k lines up a[i - 2^k] (= a[i ^ 2^k] for those i)
  // with position i, so one masked XOR performs the whole pass.
  always_comb begin
    a_o = a_i;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(stage_i) == k) a_o = a_i ^ ((a_i << (32'd1 << k)) & hi_mask(k));
    end
  end

endmodule

// File: rtl/zhegalkin_coef.sv
// Computes the Zhegalkin (ANF) coefficient vector of an N-input Boolean
// function from its truth table, one Moebius butterfly pass per clock.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : truth table present on tt
//   in_ready   : block accepts a table (IDLE only)
//   tt         : truth table, bit i = f(x) with x = i
//   out_valid  : coef/degree/nterms valid (DONE only)
//   out_ready  : consumer accepts result
//   coef       : ANF coefficients, bit m = monomial AND of x[k] for set bits of m
//   degree     : highest monomial degree present, 0 when coef == 0
//   nterms     : number of monomials present
module zhegalkin_coef
  import zhegalkin_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [(1 << N)-1:0]      tt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(1 << N)-1:0]      coef,
  output logic [$clog2(N+1)-1:0]   degree,
  output logic [N:0]               nterms
);

  localparam int unsigned W   = 1 << N;
  localparam int unsigned SW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW  = $clog2(N + 1);
  localparam int unsigned NTW = N + 1;

  state_e          state_q, state_d;
  logic [W-1:0]    work_q, work_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [W-1:0]    pass_out;

  mobius_pass #(.N(N), .SW(SW)) u_pass (
    .a_i     (work_q),
    .stage_i (stage_q),
    .a_o     (pass_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    stage_d = stage_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = tt;
          stage_d = '0;
          state_d = XFORM;
        end
      end
      XFORM: begin
        work_d  = pass_out;
        stage_d = stage_q + 1'b1;
        if (stage_q == SW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      stage_q <= stage_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign coef      = work_q;

  // Degree = largest index popcount among the present monomials.
  logic [5:0] deg_max;
  logic [5:0] pc;
  always_comb begin
    deg_max = '0;
    pc      = '0;
    for (int unsigned m = 0; m < W; m++) begin
      if (((work_q >> m) & W'(1)) != '0) begin
        pc = popcount(m);
        if (pc > deg_max) deg_max = pc;
      end
    end
  end

  assign degree = DW'(deg_max);
  assign nterms = NTW'(popcount(32'(work_q)));

endmodule

// File: tb/tb_zhegalkin_coef.sv
module tb_zhegalkin_coef;

  localparam int N   = 4;
  localparam int LAT = N + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] tt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] coef;
  logic [2:0]  degree;
  logic [4:0]  nterms;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zhegalkin_coef #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tt        (tt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coef      (coef),
    .degree    (degree),
    .nterms    (nterms)
  );

  // Reference: coefficient of monomial m is the XOR of f over all subsets of m.
  function automatic logic [15:0] ref_anf(input logic [15:0] t);
    logic [15:0] c;
    c = '0;
    for (int m = 0; m < 16; m++) begin
      int acc;
      acc = 0;
      for (int s = 0; s < 16; s++)
        if ((s & ~m) == 0) acc = acc ^ int'((t >> s) & 16'd1);
      if (acc != 0) c = c | (16'd1 << m);
    end
    return c;
  endfunction

  function automatic int ref_degree(input logic [15:0] c);
    int d;
    d = 0;
    for (int m = 0; m < 16; m++)
      if (((c >> m) & 16'd1) != 16'd0 && $countones(m) > d) d = $countones(m);
    return d;
  endfunction

  // Presents a table, waits for acceptance, then for out_valid (bounded).
  // lat counts cycles from the accepting edge to out_valid.
  task automatic start_and_wait(input logic [15:0] t, input bit hold_valid, output int lat);
    int w;
    in_valid = 1'b1;
    tt = t;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    if (!hold_valid) in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || coef !== 16'h0 || degree !== 3'd0 || nterms !== 5'd0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b coef=%h degree=%0d nterms=%0d, required 1 0 0000 0 0",
               in_ready, out_valid, coef, degree, nterms);
    end
  endtask

  task automatic test_known();
    logic [15:0] tv [5] = '{16'h0AC5, 16'hFFFF, 16'h8000, 16'h0000, 16'h6996};
    logic [15:0] cv [5] = '{16'h5173, 16'h0001, 16'h8000, 16'h0000, 16'h0116};
    int          dv [5] = '{3, 0, 4, 0, 1};
    int          nv [5] = '{8, 1, 1, 0, 4};
    int lat;
    for (int j = 0; j < 5; j++) begin
      start_and_wait(tv[j], 1'b0, lat);
      checks++;
      if (lat != LAT || coef !== cv[j] || int'(degree) != dv[j] || int'(nterms) != nv[j]) begin
        failures++;
        $display("FAIL known tt=%h: lat=%0d coef=%h deg=%0d nterms=%0d, required lat=%0d coef=%h deg=%0d nterms=%0d",
                 tv[j], lat, coef, degree, nterms, LAT, cv[j], dv[j], nv[j]);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || coef !== cv[j]) begin
        failures++;
        $display("FAIL post_handshake tt=%h: out_valid=%b in_ready=%b coef=%h, required 0 1 %h",
                 tv[j], out_valid, in_ready, coef, cv[j]);
      end
    end
  endtask

  task automatic test_involution();
    int lat;
    logic [15:0] c;
    start_and_wait(16'h6996, 1'b0, lat);
    c = coef;
    handshake();
    start_and_wait(c, 1'b0, lat);
    checks++;
    if (coef !== 16'h6996) begin
      failures++;
      $display("FAIL involution: coef=%h, required 6996", coef);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] exp_a, exp_b;
    exp_a = 16'h5173;
    exp_b = ref_anf(16'h1234);
    start_and_wait(16'h0AC5, 1'b1, lat);
    tt = 16'h1234;  // next table held on the input throughout the stall
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || coef !== exp_a || degree !== 3'd3 || nterms !== 5'd8) begin
        failures++;
        $display("FAIL stall cycle %0d: out_valid=%b in_ready=%b coef=%h deg=%0d nterms=%0d, required 1 0 %h 3 8",
                 c, out_valid, in_ready, coef, degree, nterms, exp_a);
      end
    end
    handshake();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL held_accept: in_ready=%b, required 0", in_ready);
    end
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != LAT || coef !== exp_b) begin
      failures++;
      $display("FAIL held_result: lat=%0d coef=%h, required lat=%0d coef=%h", lat, coef, LAT, exp_b);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid = 1'b1;
    tt = 16'hBEEF;
    @(posedge clk); #1;   // accepted
    in_valid = 1'b0;
    @(posedge clk); #1;   // first pass done; now in the 2nd XFORM cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || coef !== 16'h0 || degree !== 3'd0 || nterms !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b coef=%h deg=%0d nterms=%0d, required 1 0 0000 0 0",
               in_ready, out_valid, coef, degree, nterms);
    end
    start_and_wait(16'h0AC5, 1'b0, lat);
    checks++;
    if (lat != LAT || coef !== 16'h5173) begin
      failures++;
      $display("FAIL after_reset_mid: lat=%0d coef=%h, required lat=%0d coef=5173", lat, coef, LAT);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat, stall, bad;
    logic [15:0] t, e;
    bad = 0;
    for (int j = 0; j < 1000; j++) begin
      t = 16'($urandom);
      e = ref_anf(t);
      start_and_wait(t, 1'b0, lat);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
      end
      checks++;
      if (lat != LAT || out_valid !== 1'b1 || coef !== e || int'(degree) != ref_degree(e) ||
          int'(nterms) != $countones(e)) begin
        failures++;
        if (bad < 10)
          $display("FAIL random #%0d tt=%h: lat=%0d coef=%h deg=%0d nterms=%0d, required lat=%0d coef=%h deg=%0d nterms=%0d",
                   j, t, lat, coef, degree, nterms, LAT, e, ref_degree(e), $countones(e));
        bad++;
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_involution();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
